// File: rtl/axis_arbiter_if.sv
// Stream bundle between COUNT packet sources and one merged output.
// The arbiter takes the slave view; the environment driving it takes the master view.
interface axis_arbiter_if #(
   parameter int WIDTH     = 8,
   parameter int COUNT     = 4,
   parameter int SEL_WIDTH = $clog2(COUNT)
);
   logic [COUNT*WIDTH-1:0] idata;
   logic [COUNT-1:0]       ivalid;
   logic [COUNT-1:0]       ilast;
   logic [COUNT-1:0]       iready;
   logic [WIDTH-1:0]       odata;
   logic                   olast;
   logic [SEL_WIDTH-1:0]   osel;
   logic                   ovalid;
   logic                   oready;

   modport master (
      output idata, ivalid, ilast, oready,
      input  iready, odata, olast, osel, ovalid
   );

   modport slave (
      input  idata, ivalid, ilast, oready,
      output iready, odata, olast, osel, ovalid
   );
endinterface

// File: rtl/axis_arbiter.sv
// Round-robin packet arbiter: merges COUNT streams into one registered output stream.
// A grant is locked for a whole packet; one arbitration cycle separates packets.
module axis_arbiter #(
   parameter int WIDTH     = 8,
   parameter int COUNT     = 4,
   parameter int SEL_WIDTH = $clog2(COUNT)
) (
   input logic           clock,
   input logic           reset,
   axis_arbiter_if.slave bus
);
   typedef enum logic {IDLE, BUSY} state_t;

   state_t               state;
   logic [SEL_WIDTH-1:0] grant;
   logic [SEL_WIDTH-1:0] prio;
   logic [SEL_WIDTH:0]   pick;
   logic [WIDTH-1:0]     gdata;
   logic                 glast;
   logic                 gvalid;
   logic                 out_free;
   logic                 xfer_in;

   // Search P+1, P+2, ... so the lowest distance wins; MSB flags that any channel requested.
   function automatic logic [SEL_WIDTH:0] next_grant(input logic [SEL_WIDTH-1:0] p,
                                                      input logic [COUNT-1:0]     v);
      logic [SEL_WIDTH:0]   r;
      logic [SEL_WIDTH-1:0] idx;
      r = '0;
      for (int i = COUNT; i >= 1; i--) begin
         idx = SEL_WIDTH'((int'(p) + i) % COUNT);
         if (v[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   always_comb begin
      gdata = '0;
      for (int k = 0; k < COUNT; k++) begin
         if (grant == SEL_WIDTH'(k)) gdata = bus.idata[k*WIDTH +: WIDTH];
      end
   end

   assign gvalid   = bus.ivalid[grant];
   assign glast    = bus.ilast[grant];
   assign out_free = !bus.ovalid || bus.oready;
   assign xfer_in  = (state == BUSY) && gvalid && out_free;
   assign pick     = next_grant(prio, bus.ivalid);

   // Ready is withheld while reset is high, since no transfer can complete at that edge.
   always_comb begin
      bus.iready = '0;
      if (!reset && state == BUSY && out_free) bus.iready[grant] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         prio       <= SEL_WIDTH'(COUNT - 1);
         grant      <= '0;
         bus.ovalid <= 1'b0;
         bus.olast  <= 1'b0;
         bus.osel   <= '0;
         bus.odata  <= '0;
      end else begin
         if (xfer_in) begin
            bus.odata  <= gdata;
            bus.olast  <= glast;
            bus.osel   <= grant;
            bus.ovalid <= 1'b1;
         end else if (bus.oready) begin
            bus.ovalid <= 1'b0;
         end

         unique case (state)
            IDLE: begin
               if (pick[SEL_WIDTH]) begin
                  grant <= pick[SEL_WIDTH-1:0];
                  prio  <= pick[SEL_WIDTH-1:0];
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (xfer_in && glast) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axis_arbiter.sv
// Randomized scoreboard bench for axis_arbiter, plus a small COUNT=3 instance
// that checks index wrap for a non-power-of-two channel count.
module tb_axis_arbiter;
   localparam int W = 8;
   localparam int N = 4;

   typedef struct packed {logic [W-1:0] d; logic l;} el_t;
   typedef struct packed {logic [W-1:0] d; logic l; logic [1:0] s;} exp_t;

   logic clock;
   logic reset;

   axis_arbiter_if #(.WIDTH(W), .COUNT(N)) bus ();
   axis_arbiter_if #(.WIDTH(W), .COUNT(3)) bus3 ();

   axis_arbiter #(.WIDTH(W), .COUNT(N)) dut (.clock(clock), .reset(reset), .bus(bus));
   axis_arbiter #(.WIDTH(W), .COUNT(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3));

   int n_tests = 0;
   int n_fail  = 0;

   // Stimulus state
   el_t        src_q[N][$];
   int         vprob = 100;
   int         opct  = 100;
   bit         rst_req = 1;
   logic [N-1:0] acc = '0;
   bit         mon_en = 0;

   // Reference model state: a grant owner, the last granted channel, one output slot
   exp_t sb[$];
   bit   m_busy = 0;
   bit   m_full = 0;
   int   m_g = 0;
   int   m_p = N - 1;

   int   n3 = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Packet-level model: a free owner is chosen round-robin from the channels
   // presenting data; its elements enter the single output slot when it is free.
   always @(posedge clock) begin
      bit   free;
      int   c;
      exp_t e;
      if (reset) begin
         m_busy = 0;
         m_full = 0;
         m_p    = N - 1;
         sb.delete();
      end else begin
         free = !m_full || bus.oready;
         if (m_busy) begin
            if (bus.ivalid[m_g] && free) begin
               e.d = bus.idata[m_g*W +: W];
               e.l = bus.ilast[m_g];
               e.s = 2'(m_g);
               sb.push_back(e);
               m_full = 1;
               if (bus.ilast[m_g]) m_busy = 0;
            end else if (m_full && bus.oready) begin
               m_full = 0;
            end
         end else begin
            if (m_full && bus.oready) m_full = 0;
            for (int i = 1; i <= N; i++) begin
               c = (m_p + i) % N;
               if (bus.ivalid[c]) begin
                  m_g    = c;
                  m_p    = c;
                  m_busy = 1;
                  break;
               end
            end
         end
      end
   end

   // Monitor: compare handshake and popped scoreboard entries away from the clock edge
   always @(negedge clock) begin
      logic [N-1:0] exp_rdy;
      exp_t         h;
      acc = bus.ivalid & bus.iready;
      if (mon_en) begin
         exp_rdy = '0;
         if (!reset && m_busy && (!m_full || bus.oready)) exp_rdy[m_g] = 1'b1;
         chk("iready", 32'(bus.iready), 32'(exp_rdy));
         chk("ovalid", 32'(bus.ovalid), 32'(m_full));
         if (bus.ovalid) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 32'(bus.ovalid), 32'(0));
            end else begin
               h = sb[0];
               chk("odata", 32'(bus.odata), 32'(h.d));
               chk("olast", 32'(bus.olast), 32'(h.l));
               chk("osel", 32'(bus.osel), 32'(h.s));
               if (bus.oready) void'(sb.pop_front());
            end
         end
         if (bus3.ovalid) begin
            chk("c3_range", 32'(bus3.osel < 2'd3), 32'(1));
            chk("c3_data", 32'(bus3.odata), 32'(8'h11 * (bus3.osel + 1)));
            chk("c3_last", 32'(bus3.olast), 32'(1));
            if (n3 < 6) begin
               chk("c3_order", 32'(bus3.osel), 32'(n3 % 3));
               n3++;
            end
         end
         chk("c3_rdy_onehot", 32'($countones(bus3.iready) <= 1), 32'(1));
      end
   end

   function automatic bit src_empty();
      for (int k = 0; k < N; k++) if (src_q[k].size() != 0) return 0;
      return 1;
   endfunction

   task automatic push_el(input int ch, input logic [W-1:0] d, input logic l);
      el_t e;
      e.d = d;
      e.l = l;
      src_q[ch].push_back(e);
   endtask

   task automatic push_pkt(input int ch, input int len);
      for (int i = 0; i < len; i++) push_el(ch, W'($urandom), (i == len - 1));
   endtask

   task automatic cyc();
      @(posedge clock);
      for (int k = 0; k < N; k++) if (acc[k]) void'(src_q[k].pop_front());
      #1;
      reset      = rst_req;
      bus.oready = ($urandom_range(99) < opct);
      for (int k = 0; k < N; k++) begin
         if (src_q[k].size() != 0 && $urandom_range(99) < vprob) begin
            bus.ivalid[k]          = 1'b1;
            bus.idata[k*W +: W]    = src_q[k][0].d;
            bus.ilast[k]           = src_q[k][0].l;
         end else begin
            bus.ivalid[k]          = 1'b0;
            bus.idata[k*W +: W]    = W'($urandom);
            bus.ilast[k]           = 1'($urandom);
         end
      end
   endtask

   task automatic drain(input string nm, input int budget);
      int n;
      n = 0;
      while ((!src_empty() || m_busy || m_full) && n < budget) begin
         cyc();
         n++;
      end
      n_tests++;
      if (n >= budget) begin
         n_fail++;
         $display("FAIL %s_timeout: still busy after %0d cycles, required idle", nm, n);
      end
   endtask

   task automatic pulse_reset();
      rst_req = 1;
      cyc();
      rst_req = 0;
      cyc();
   endtask

   initial begin
      reset       = 1'b1;
      bus.idata   = '0;
      bus.ivalid  = '0;
      bus.ilast   = '0;
      bus.oready  = 1'b1;
      bus3.idata  = 24'h33_22_11;
      bus3.ivalid = 3'b111;
      bus3.ilast  = 3'b111;
      bus3.oready = 1'b1;

      cyc();
      cyc();
      @(negedge clock);
      chk("rst_ovalid", 32'(bus.ovalid), 32'(0));
      chk("rst_odata", 32'(bus.odata), 32'(0));
      chk("rst_olast", 32'(bus.olast), 32'(0));
      chk("rst_osel", 32'(bus.osel), 32'(0));
      chk("rst_iready", 32'(bus.iready), 32'(0));
      mon_en  = 1;
      rst_req = 0;

      // Three-element packet on channel 0
      push_el(0, 8'h11, 1'b0);
      push_el(0, 8'h22, 1'b0);
      push_el(0, 8'h33, 1'b1);
      drain("single_pkt", 40);

      // All channels requesting single-element packets, from a fresh reset
      pulse_reset();
      for (int r = 0; r < 3; r++) for (int k = 0; k < N; k++) push_pkt(k, 1);
      drain("round_robin", 100);

      // Downstream stall in the middle of a channel 2 packet
      push_pkt(2, 6);
      repeat (4) cyc();
      opct = 0;
      repeat (3) cyc();
      opct = 100;
      drain("stall", 60);

      // Grant channel 3, then wrap to 0 before 2
      push_pkt(3, 2);
      drain("grant3", 30);
      push_pkt(0, 2);
      push_pkt(2, 1);
      drain("wrap", 40);

      // Reset while channel 1 is mid-packet with the output register loaded
      push_pkt(1, 6);
      repeat (5) cyc();
      pulse_reset();
      @(negedge clock);
      chk("midrst_ovalid", 32'(bus.ovalid), 32'(0));
      chk("midrst_iready", 32'(bus.iready), 32'(0));
      push_pkt(3, 1);
      drain("after_reset", 60);

      // Randomized traffic with backpressure and one reset in the middle
      vprob = 70;
      opct  = 60;
      for (int it = 0; it < 600; it++) begin
         if ($urandom_range(99) < 30) begin
            int ch;
            ch = $urandom_range(N - 1);
            if (src_q[ch].size() < 8) push_pkt(ch, $urandom_range(4, 1));
         end
         rst_req = (it == 300);
         cyc();
      end
      rst_req = 0;
      drain("random", 3000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end
endmodule
